adder_share_sched: RTL
======================

# adder_share_sched

Two-requester scheduler that time-shares a single W-bit arithmetic/logic unit (add, subtract, XOR, AND) between two independent operand sources. Round-robin arbitration selects one operand pair per cycle and issues it to the unit. A 2-entry result FIFO tagged with the requester ID decouples the unit from a slow consumer. The block sits between the project's input-capture logic and its output-pin mux, inside the `tt_um_*` top.

## Interface
Parameters:
- `W`, 8, operand and result width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  enable from the harness; low blocks new grants.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle.
- `req0_op` / `req1_op`  in  2  opcode: 0 ADD, 1 SUB (a−b), 2 XOR, 3 AND.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  operands.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  consumer takes the head.
- `res_data`  out  W  result.
- `res_carry`  out  1  ADD: carry-out; SUB: borrow (a<b); XOR/AND: 0.
- `res_id`  out  1  requester that produced the result.

## Operation
- Handshake: transfer on `valid & ready`. The requester holds `op`/`a`/`b` stable while `valid` and not `ready`. `valid` must not drop before transfer.
- Space: `space = !full | (res_ready & res_valid)`. Push into a full FIFO is allowed only with a simultaneous pop.
- Grant, decided combinationally:
  - If `ena=0` or `space=0`: no grant, both readies 0.
  - If exactly one valid: that requester is granted.
  - If both valid: the requester pointed to by `rr_ptr` is granted.
- Pointer: on an accepted transfer, `rr_ptr` becomes the non-granted requester. With no transfer, `rr_ptr` holds.
- Datapath:
  - Results are computed in W+1 bits, truncated to W for `res_data`.
  - ADD carry is bit W.
  - SUB is `a + ~b + 1`, with `res_carry` = inverted bit W (borrow).
- FIFO:
  - 2 entries of {id, carry, data}; head presented on the `res_*` ports.
  - Order is strictly the order of acceptance.
- Output side: draining is independent of `ena`.
- Reset (asynchronous, any time):
  - FIFO empties and `rr_ptr` is set to 0.
  - In-flight data is discarded; no partial results.
  - All outputs are 0 while `rst_n=0` and until the first accept.

## Timing
- Readies are combinational from valids, `ena`, FIFO state and `res_ready`. There is no combinational path from operands to readies.
- Latency: an operation accepted at edge N is visible on `res_*` after edge N when the FIFO was empty, so `res_valid=1` in cycle N+1.
- Throughput: one operation per cycle sustained while `res_ready=1`.
- Full FIFO with `res_ready=0`: both readies 0 and the head is stable.
- Full FIFO with `res_ready=1`: pop and push happen on the same edge; count stays 2.
- Empty FIFO with a push: count becomes 1. A simultaneous `res_ready` has no effect because `res_valid` was 0.
- `res_*` only changes on a pop or on the first push into an empty FIFO.

## Structure
- Package `adder_share_pkg`:
  - `op_e` enum (ADD, SUB, XOR, AND).
  - Result-entry struct {id, carry, data}.
  - FIFO depth constant 2.
- Sub-module `share_alu`: combinational unit taking `op`, `a`, `b` and producing `data` and `carry`. It is instantiated once, fed by the grant mux.
- The arbiter, pointer and FIFO (2 registers plus write/read pointers and a count) stay in the top.

## Test plan
- Single op: reset, then req0 ADD a=8'hF0, b=8'h20. Expect `req0_ready=1` the same cycle; next cycle `res_valid=1`, `res_data=8'h10`, `res_carry=1`, `res_id=0`.
- Contention: both valid continuously, `res_ready=1`, ops req0 SUB 5−7, req1 XOR 8'hAA^8'h0F.
  - Grants alternate 0,1,0,1 starting with 0.
  - Results: `res_data=8'hFE`, `res_carry=1`; then `8'hA5`, carry 0.
- Backpressure: `res_ready=0`, req1 issues 3 ops.
  - First two accepted; third sees `req1_ready=0`.
  - Raising `res_ready` pops head and accepts the third on the same edge; order is preserved.
- Enable gating: FIFO holds 2 results, `ena=0`, both requesters valid.
  - No grants.
  - Both results drain with `res_ready=1`; `res_valid` drops to 0 after the second pop.
- Mid-operation reset: FIFO full and pointer=1; assert `rst_n=0` asynchronously between edges.
  - Outputs go to 0 immediately.
  - After release, with both valid, requester 0 is granted first.
- AND and carry rules: AND 8'hFF & 8'h3C gives `res_data=8'h3C`, `res_carry=0`. SUB 9−9 gives `res_data=0`, `res_carry=0`.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared types for the two-requester ALU scheduler: opcodes, result-FIFO entry, FIFO depth.
package adder_share_pkg;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_XOR = 2'd2,
      OP_AND = 2'd3
   } op_e;

   typedef struct packed {
      logic              id;
      logic              carry;
      logic [DATA_W-1:0] data;
   } res_entry_t;

endpackage

// File: rtl/share_alu.sv
// Combinational W-bit add/sub/xor/and unit; carry is carry-out for ADD and borrow for SUB.
module share_alu
   import adder_share_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] data,
   output logic         carry
);

   logic [W:0] wide;

   always_comb begin
      wide  = '0;
      carry = 1'b0;
      case (op)
         OP_ADD: begin
            wide  = {1'b0, a} + {1'b0, b};
            carry = wide[W];
         end
         OP_SUB: begin
            // No carry out of a + ~b + 1 means a < b, i.e. a borrow.
            wide  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            carry = ~wide[W];
         end
         OP_XOR:  wide = {1'b0, a ^ b};
         OP_AND:  wide = {1'b0, a & b};
         default: wide = '0;
      endcase
   end

   assign data = wide[W-1:0];

endmodule

// File: rtl/adder_share_sched.sv
// Round-robin share of one ALU between two requesters into a 2-entry tagged result FIFO.
// Result visible the cycle after accept; readies drop when the FIFO is full and not being popped.
module adder_share_sched
   import adder_share_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [1:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [1:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         res_carry,
   output logic         res_id
);

   res_entry_t   fifo_q [FIFO_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         rr_ptr;
   logic [1:0]   count;

   logic         full;
   logic         space;
   logic         pop;
   logic         push;
   logic         gnt0;
   logic         gnt1;
   logic         sel;

   op_e          alu_op;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] alu_data;
   logic         alu_carry;

   assign full      = (count == 2'(FIFO_DEPTH));
   assign res_valid = (count != 2'd0);
   assign pop       = res_valid & res_ready;
   assign space     = ~full | pop;

   // Grant looks only at valids and FIFO state, never at operands.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && ena && space) begin
         if (req0_valid && req1_valid) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign push       = gnt0 | gnt1;
   assign sel        = gnt1;

   assign alu_op = sel ? op_e'(req1_op) : op_e'(req0_op);
   assign alu_a  = sel ? req1_a : req0_a;
   assign alu_b  = sel ? req1_b : req0_b;

   share_alu #(.W(W)) u_alu (
      .op    (alu_op),
      .a     (alu_a),
      .b     (alu_b),
      .data  (alu_data),
      .carry (alu_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         rr_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= '{id: sel, carry: alu_carry, data: alu_data};
            wr_ptr         <= ~wr_ptr;
            rr_ptr         <= ~sel;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Head register is shown even when empty, so res_* only move on pop or push-into-empty.
   assign res_data  = fifo_q[rd_ptr].data;
   assign res_carry = fifo_q[rd_ptr].carry;
   assign res_id    = fifo_q[rd_ptr].id;

endmodule
